// File: rtl/data_ram_resp.sv
// data_ram_resp: data-side memory responder for the MEM stage.
// Holds DEPTH big-endian 32-bit words with per-byte write enables, returns the
// full read word on a registered data_o, and stalls the pipeline for
// WAIT_CYCLES extra cycles per access. The final cycle of every access raises ack_o.
// Optional feature: define DRAM_BOUNDS_CHK_EN to flag and suppress accesses
// whose address lies beyond the array (err_o). Without it, the upper address
// bits alias and err_o is tied low.
module data_ram_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                latch_req;

    // Latched request; the word index and range flag are all that the
    // address contributes once the request is captured.
    logic                req_we_q;
    logic [3:0]          req_sel_q;
    logic [ADDR_W-1:0]   req_idx_q;
    logic                req_oor_q;
    logic [31:0]         req_data_q;
    logic [31:0]         data_q;

    logic [31:0]         mem [DEPTH];

    logic                in_oor;
    logic                unused_addr;

`ifdef DRAM_BOUNDS_CHK_EN
    assign in_oor      = |addr_i[31:ADDR_W+2];
    assign unused_addr = &{1'b0, addr_i[1:0]};
`else
    assign in_oor      = 1'b0;
    assign unused_addr = &{1'b0, addr_i[1:0], addr_i[31:ADDR_W+2]};
`endif

    // With zero wait states the access completes on the same edge that sees
    // the request in IDLE, so the live inputs act as the request there.
    logic                eff_we;
    logic [3:0]          eff_sel;
    logic [ADDR_W-1:0]   eff_idx;
    logic                eff_oor;
    logic [31:0]         eff_data;
    logic                go_done;

    assign eff_we   = (state_q == IDLE) ? we_i                 : req_we_q;
    assign eff_sel  = (state_q == IDLE) ? sel_i                : req_sel_q;
    assign eff_idx  = (state_q == IDLE) ? addr_i[ADDR_W+1:2]   : req_idx_q;
    assign eff_oor  = (state_q == IDLE) ? in_oor               : req_oor_q;
    assign eff_data = (state_q == IDLE) ? data_i               : req_data_q;
    assign go_done  = (state_d == DONE) && !rst;

    // Next-state, wait counter and handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        stall_o   = 1'b0;
        ack_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_o = ce_i;
                if (ce_i) begin
                    latch_req = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (!ce_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                ack_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall_o = 1'b0;
        end
    end

`ifdef DRAM_BOUNDS_CHK_EN
    assign err_o = ack_o & req_oor_q;
`else
    assign err_o = 1'b0;
`endif

    assign data_o = data_q;

    // State, counter, request latch and read-data register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is only evaluated at the rising edge.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            req_we_q   <= 1'b0;
            req_sel_q  <= 4'd0;
            req_idx_q  <= '0;
            req_oor_q  <= 1'b0;
            req_data_q <= 32'd0;
            data_q     <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_req) begin
                req_we_q   <= we_i;
                req_sel_q  <= sel_i;
                req_idx_q  <= addr_i[ADDR_W+1:2];
                req_oor_q  <= in_oor;
                req_data_q <= data_i;
            end
            if (go_done && !eff_we) begin
                data_q <= eff_oor ? 32'd0 : mem[eff_idx];
            end
        end
    end

    // Byte-lane write into the array on entry to DONE.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; contents survive rst, only the write enable is gated.
        if (go_done && eff_we && !eff_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_sel[i]) begin
                    mem[eff_idx][i*8 +: 8] <= eff_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: directed bench for data_ram_resp with three instances
// (WAIT_CYCLES = 1, 0, 3). Bounds expectations follow DRAM_BOUNDS_CHK_EN.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce   [3];
    logic        we   [3];
    logic [3:0]  sel  [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        stall[3];
    logic        ack  [3];
    logic        err  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_ram_resp #(.DEPTH(1024), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .sel_i(sel[0]),
        .addr_i(addr[0]), .data_i(din[0]), .data_o(dout[0]),
        .stall_o(stall[0]), .ack_o(ack[0]), .err_o(err[0]));

    data_ram_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .sel_i(sel[1]),
        .addr_i(addr[1]), .data_i(din[1]), .data_o(dout[1]),
        .stall_o(stall[1]), .ack_o(ack[1]), .err_o(err[1]));

    data_ram_resp #(.DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .ce_i(ce[2]), .we_i(we[2]), .sel_i(sel[2]),
        .addr_i(addr[2]), .data_i(din[2]), .data_o(dout[2]),
        .stall_o(stall[2]), .ack_o(ack[2]), .err_o(err[2]));

    // Drive one access on instance k and follow it until ack or 16 cycles.
    // drop_at > 0 lowers ce at the start of that cycle. ce stays high after
    // an ack so a following access can run back to back.
    task automatic access(input int k, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d, input int drop_at,
                          output int stalls, output int ack_cyc,
                          output logic [31:0] rd, output logic [31:0] pre_rd,
                          output logic er);
        @(posedge clk); #1;
        ce[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; din[k] = d;
        stalls = 0; ack_cyc = 0; rd = 32'hx; pre_rd = 32'hx; er = 1'bx;
        for (int c = 1; c <= 16; c++) begin
            if (drop_at == c) ce[k] = 1'b0;
            @(negedge clk);
            if (c == 1) pre_rd = dout[k];
            if (ack[k] === 1'b1) begin
                ack_cyc = c; rd = dout[k]; er = err[k];
                break;
            end
            if (stall[k] === 1'b1) stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1;
        ce[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) ce[k] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (stall[k] !== 1'b0) begin n_bad++; $display("FAIL reset_stall[%0d]: got %b want 0", k, stall[k]); end
            n_cmp++; if (ack[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ack[%0d]: got %b want 0", k, ack[k]); end
            n_cmp++; if (err[k] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d]: got %b want 0", k, err[k]); end
            n_cmp++; if (dout[k] !== 32'd0) begin n_bad++; $display("FAIL reset_data[%0d]: got %h want 0", k, dout[k]); end
            ce[k] = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_timing();
        int st, ac; logic [31:0] rd, pr; logic er;
        access(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 0, st, ac, rd, pr, er);
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL sw_stall_cycles: got %0d want 2", st); end
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL sw_ack_cycle: got %0d want 3", ac); end
        n_cmp++; if (stall[0] !== 1'b0) begin n_bad++; $display("FAIL sw_stall_at_ack: got %b want 0", stall[0]); end
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL sw_keeps_data_o: got %h want 0", rd); end
        idle(0);
        access(0, 1'b0, 4'b1111, 32'h10, 32'h0, 0, st, ac, rd, pr, er);
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL lw_ack_cycle: got %0d want 3", ac); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data: got %h want DEADBEEF", rd); end
        idle(0);
    endtask

    task automatic test_byte_lanes();
        int st, ac; logic [31:0] rd, pr; logic er;
        access(0, 1'b1, 4'b0100, 32'h11, 32'h55555555, 0, st, ac, rd, pr, er); idle(0);
        access(0, 1'b0, 4'b0001, 32'h10, 32'h0, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (rd !== 32'hDE55BEEF) begin n_bad++; $display("FAIL sb_lane1: got %h want DE55BEEF", rd); end
        access(0, 1'b1, 4'b0011, 32'h12, 32'h12341234, 0, st, ac, rd, pr, er); idle(0);
        access(0, 1'b0, 4'b0000, 32'h13, 32'h0, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (rd !== 32'hDE551234) begin n_bad++; $display("FAIL sh_low_half: got %h want DE551234", rd); end
        access(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL sel0_acks: got %0d want 3", ac); end
        access(0, 1'b0, 4'b1111, 32'h10, 32'h0, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (rd !== 32'hDE551234) begin n_bad++; $display("FAIL sel0_noop: got %h want DE551234", rd); end
    endtask

    task automatic test_back_to_back();
        int st, ac; logic [31:0] rd, pr; logic er;
        access(1, 1'b1, 4'b1111, 32'h100, 32'hA5A5A5A5, 0, st, ac, rd, pr, er); idle(1);
        access(1, 1'b1, 4'b1111, 32'h104, 32'h5A5A5A5A, 0, st, ac, rd, pr, er); idle(1);
        access(1, 1'b0, 4'b1111, 32'h100, 32'h0, 0, st, ac, rd, pr, er);
        n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL b2b_stall1: got %0d want 1", st); end
        n_cmp++; if (ac !== 2) begin n_bad++; $display("FAIL b2b_ack1: got cycle %0d want 2", ac); end
        n_cmp++; if (pr !== 32'd0) begin n_bad++; $display("FAIL b2b_hold1: got %h want 0", pr); end
        n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL b2b_data1: got %h want A5A5A5A5", rd); end
        access(1, 1'b0, 4'b1111, 32'h104, 32'h0, 0, st, ac, rd, pr, er);
        n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL b2b_stall2: got %0d want 1", st); end
        n_cmp++; if (ac + 2 !== 4) begin n_bad++; $display("FAIL b2b_ack2: got cycle %0d want 4", ac + 2); end
        n_cmp++; if (pr !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL b2b_hold2: got %h want A5A5A5A5", pr); end
        n_cmp++; if (rd !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL b2b_data2: got %h want 5A5A5A5A", rd); end
        idle(1);
    endtask

    task automatic test_abort();
        int st, ac; logic [31:0] rd, pr; logic er;
        access(2, 1'b1, 4'b1111, 32'h20, 32'h0BADC0DE, 0, st, ac, rd, pr, er); idle(2);
        n_cmp++; if (st !== 4) begin n_bad++; $display("FAIL w3_stall_cycles: got %0d want 4", st); end
        n_cmp++; if (ac !== 5) begin n_bad++; $display("FAIL w3_ack_cycle: got %0d want 5", ac); end
        access(2, 1'b1, 4'b1111, 32'h20, 32'hCAFEF00D, 3, st, ac, rd, pr, er);
        n_cmp++; if (ac !== 0) begin n_bad++; $display("FAIL abort_no_ack: got ack at cycle %0d want none", ac); end
        n_cmp++; if (dout[2] !== 32'd0) begin n_bad++; $display("FAIL abort_data_o: got %h want 0", dout[2]); end
        access(2, 1'b0, 4'b1111, 32'h20, 32'h0, 0, st, ac, rd, pr, er); idle(2);
        n_cmp++; if (rd !== 32'h0BADC0DE) begin n_bad++; $display("FAIL abort_no_write: got %h want 0BADC0DE", rd); end
    endtask

    task automatic test_reset_mid();
        int st, ac; logic [31:0] rd, pr; logic er;
        access(2, 1'b1, 4'b1111, 32'h40, 32'h11223344, 0, st, ac, rd, pr, er); idle(2);
        access(2, 1'b0, 4'b1111, 32'h40, 32'h0, 0, st, ac, rd, pr, er); idle(2);
        n_cmp++; if (dout[2] !== 32'h11223344) begin n_bad++; $display("FAIL pre_reset_read: got %h want 11223344", dout[2]); end
        @(posedge clk); #1;
        ce[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'b1111; addr[2] = 32'h40; din[2] = 32'h99999999;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (stall[2] !== 1'b1) begin n_bad++; $display("FAIL busy_stall: got %b want 1", stall[2]); end
        rst = 1'b1;
        #1;
        n_cmp++; if (stall[2] !== 1'b0) begin n_bad++; $display("FAIL stall_in_rst: got %b want 0", stall[2]); end
        @(posedge clk); #1;
        rst = 1'b0; ce[2] = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall[2] !== 1'b0) begin n_bad++; $display("FAIL post_rst_stall: got %b want 0", stall[2]); end
        n_cmp++; if (ack[2] !== 1'b0) begin n_bad++; $display("FAIL post_rst_ack: got %b want 0", ack[2]); end
        n_cmp++; if (dout[2] !== 32'd0) begin n_bad++; $display("FAIL post_rst_data: got %h want 0", dout[2]); end
        access(2, 1'b0, 4'b1111, 32'h40, 32'h0, 0, st, ac, rd, pr, er); idle(2);
        n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL rst_no_write: got %h want 11223344", rd); end
        access(0, 1'b0, 4'b1111, 32'h10, 32'h0, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (rd !== 32'hDE551234) begin n_bad++; $display("FAIL mem_survives_rst: got %h want DE551234", rd); end
    endtask

    task automatic test_bounds();
        int st, ac; logic [31:0] rd, pr; logic er;
        logic        exp_err;
        logic [31:0] exp_far, exp_zero;
`ifdef DRAM_BOUNDS_CHK_EN
        exp_err = 1'b1; exp_far = 32'd0;        exp_zero = 32'h01020304;
`else
        exp_err = 1'b0; exp_far = 32'h77778888; exp_zero = 32'h77778888;
`endif
        access(0, 1'b1, 4'b1111, 32'h0, 32'h01020304, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL inrange_err: got %b want 0", er); end
        access(0, 1'b1, 4'b1111, 32'h1000, 32'h77778888, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL oor_sw_ack: got %0d want 3", ac); end
        n_cmp++; if (er !== exp_err) begin n_bad++; $display("FAIL oor_sw_err: got %b want %b", er, exp_err); end
        access(0, 1'b0, 4'b1111, 32'h1000, 32'h0, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (rd !== exp_far) begin n_bad++; $display("FAIL oor_lw_data: got %h want %h", rd, exp_far); end
        n_cmp++; if (er !== exp_err) begin n_bad++; $display("FAIL oor_lw_err: got %b want %b", er, exp_err); end
        access(0, 1'b0, 4'b1111, 32'h0, 32'h0, 0, st, ac, rd, pr, er); idle(0);
        n_cmp++; if (rd !== exp_zero) begin n_bad++; $display("FAIL alias_word0: got %h want %h", rd, exp_zero); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL word0_err: got %b want 0", er); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            ce[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'd0; addr[k] = 32'd0; din[k] = 32'd0;
        end
        test_reset();
        test_timing();
        test_byte_lanes();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_bounds();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
